// File: rtl/rf_write_scheduler.sv
// Register file write-port scheduler: ALU/load arbitration, in-order load
// buffer with WAW kill, and per-register outstanding-load scoreboard.
module rf_write_scheduler #(
  parameter int INDEX_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH  = 32,
  parameter int N_REGS          = 1 << INDEX_BIT_WIDTH,
  parameter int LD_DEPTH        = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       aluWrtEn,
  input  logic [INDEX_BIT_WIDTH-1:0] aluWrtIndex,
  input  logic [DATA_BIT_WIDTH-1:0]  aluData,
  input  logic                       ldValid,
  input  logic [INDEX_BIT_WIDTH-1:0] ldIndex,
  input  logic [DATA_BIT_WIDTH-1:0]  ldData,
  output logic                       ldReady,
  input  logic                       issueLd,
  input  logic [INDEX_BIT_WIDTH-1:0] issueLdIndex,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
  output logic                       stall,
  output logic                       aluHold,
  output logic                       rfWrtEn,
  output logic [INDEX_BIT_WIDTH-1:0] rfWrtIndex,
  output logic [DATA_BIT_WIDTH-1:0]  rfDataIn,
  output logic                       sbOverflow
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = $clog2(LD_DEPTH + 1);

  logic [1:0] cnt_q [N_REGS];
  logic [1:0] cnt_d [N_REGS];
  logic       ovf_q, ovf_d;

  logic [INDEX_BIT_WIDTH-1:0] bidx_q [LD_DEPTH];
  logic [INDEX_BIT_WIDTH-1:0] bidx_d [LD_DEPTH];
  logic [DATA_BIT_WIDTH-1:0]  bdat_q [LD_DEPTH];
  logic [DATA_BIT_WIDTH-1:0]  bdat_d [LD_DEPTH];
  logic                       bkill_q [LD_DEPTH];
  logic                       bkill_d [LD_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] fill_q, fill_d;

  logic                       rel_vld_q, rel_vld_d;
  logic [INDEX_BIT_WIDTH-1:0] rel_idx_q, rel_idx_d;

  logic                       wen_q, wen_d;
  logic [INDEX_BIT_WIDTH-1:0] widx_q, widx_d;
  logic [DATA_BIT_WIDTH-1:0]  wdat_q, wdat_d;

  logic full, empty, push, pop, head_kill;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(LD_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (fill_q == CW'(LD_DEPTH));
  assign empty     = (fill_q == '0);
  assign ldReady   = ~full;
  assign aluHold   = full;
  assign push      = ldValid & ~full;
  assign head_kill = bkill_q[rd_ptr_q];
  // A killed head never needs the port, so it can drain under ALU traffic
  assign pop       = ~empty & (~aluWrtEn | head_kill);

  assign stall = (cnt_q[rdIndex1] != 2'd0) | (cnt_q[rdIndex2] != 2'd0);

  assign rfWrtEn    = wen_q;
  assign rfWrtIndex = widx_q;
  assign rfDataIn   = wdat_q;
  assign sbOverflow = ovf_q;

  always_comb begin
    for (int i = 0; i < LD_DEPTH; i++) begin
      bidx_d[i]  = bidx_q[i];
      bdat_d[i]  = bdat_q[i];
      bkill_d[i] = bkill_q[i];
      if (aluWrtEn && bidx_q[i] == aluWrtIndex) begin
        bkill_d[i] = 1'b1;
      end
    end
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      bidx_d[wr_ptr_q]  = ldIndex;
      bdat_d[wr_ptr_q]  = ldData;
      bkill_d[wr_ptr_q] = aluWrtEn && (aluWrtIndex == ldIndex);
      wr_ptr_d          = nxt(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = nxt(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_comb begin
    wen_d     = 1'b0;
    widx_d    = widx_q;
    wdat_d    = wdat_q;
    rel_vld_d = pop;
    rel_idx_d = pop ? bidx_q[rd_ptr_q] : rel_idx_q;
    if (aluWrtEn) begin
      wen_d  = 1'b1;
      widx_d = aluWrtIndex;
      wdat_d = aluData;
    end else if (pop) begin
      wen_d  = ~head_kill;
      widx_d = bidx_q[rd_ptr_q];
      wdat_d = bdat_q[rd_ptr_q];
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int r = 0; r < N_REGS; r++) begin
      logic inc, dec;
      inc      = issueLd && (issueLdIndex == INDEX_BIT_WIDTH'(r));
      dec      = rel_vld_q && (rel_idx_q == INDEX_BIT_WIDTH'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        if (cnt_q[r] == 2'd3) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + 2'd1;
        end
      end else if (dec && !inc && cnt_q[r] != 2'd0) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      for (int i = 0; i < LD_DEPTH; i++) begin
        bidx_q[i]  <= '0;
        bdat_q[i]  <= '0;
        bkill_q[i] <= 1'b0;
      end
      ovf_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      rel_vld_q <= 1'b0;
      rel_idx_q <= '0;
      wen_q     <= 1'b0;
      widx_q    <= '0;
      wdat_q    <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      for (int i = 0; i < LD_DEPTH; i++) begin
        bidx_q[i]  <= bidx_d[i];
        bdat_q[i]  <= bdat_d[i];
        bkill_q[i] <= bkill_d[i];
      end
      ovf_q     <= ovf_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      rel_vld_q <= rel_vld_d;
      rel_idx_q <= rel_idx_d;
      wen_q     <= wen_d;
      widx_q    <= widx_d;
      wdat_q    <= wdat_d;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_rf_write_scheduler;

  localparam int IW = 4;
  localparam int DW = 32;
  localparam int LD_DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          aluWrtEn;
  logic [IW-1:0] aluWrtIndex;
  logic [DW-1:0] aluData;
  logic          ldValid;
  logic [IW-1:0] ldIndex;
  logic [DW-1:0] ldData;
  logic          ldReady;
  logic          issueLd;
  logic [IW-1:0] issueLdIndex;
  logic [IW-1:0] rdIndex1, rdIndex2;
  logic          stall, aluHold;
  logic          rfWrtEn;
  logic [IW-1:0] rfWrtIndex;
  logic [DW-1:0] rfDataIn;
  logic          sbOverflow;

  rf_write_scheduler #(
    .INDEX_BIT_WIDTH(IW), .DATA_BIT_WIDTH(DW), .LD_DEPTH(LD_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .aluWrtEn(aluWrtEn), .aluWrtIndex(aluWrtIndex), .aluData(aluData),
    .ldValid(ldValid), .ldIndex(ldIndex), .ldData(ldData),
    .ldReady(ldReady),
    .issueLd(issueLd), .issueLdIndex(issueLdIndex),
    .rdIndex1(rdIndex1), .rdIndex2(rdIndex2),
    .stall(stall), .aluHold(aluHold),
    .rfWrtEn(rfWrtEn), .rfWrtIndex(rfWrtIndex), .rfDataIn(rfDataIn),
    .sbOverflow(sbOverflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: buffer as a queue, counts as plain ints
  typedef struct {
    int          idx;
    logic [31:0] dat;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  int          mc[16];
  bit          movf;
  bit          mrel_v;
  int          mrel_i;
  bit          ewen;
  int          eidx;
  logic [31:0] edat;
  bit          ld_acc;

  always @(posedge clk) begin
    bit m_push, m_pop;
    int ai, li, ii;
    ai = int'(aluWrtIndex);
    li = int'(ldIndex);
    ii = int'(issueLdIndex);
    if (!reset_n) begin
      mq.delete();
      foreach (mc[k]) mc[k] = 0;
      movf = 0; mrel_v = 0; mrel_i = 0;
      ewen = 0; eidx = 0; edat = 0; ld_acc = 0;
    end else begin
      m_push = ldValid && (mq.size() < LD_DEPTH);
      ld_acc = m_push;
      m_pop  = 0;
      ewen   = 0;
      if (aluWrtEn) begin
        ewen = 1; eidx = ai; edat = aluData;
        m_pop = (mq.size() > 0) && mq[0].kill;
      end else if (mq.size() > 0) begin
        m_pop = 1;
        ewen = !mq[0].kill; eidx = mq[0].idx; edat = mq[0].dat;
      end
      if (!(issueLd && mrel_v && ii == mrel_i)) begin
        if (issueLd) begin
          if (mc[ii] == 3) movf = 1;
          else mc[ii]++;
        end
        if (mrel_v && mc[mrel_i] > 0) mc[mrel_i]--;
      end
      mrel_v = m_pop;
      if (m_pop) mrel_i = mq[0].idx;
      foreach (mq[k])
        if (aluWrtEn && mq[k].idx == ai) mq[k].kill = 1;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{li, ldData, aluWrtEn && ai == li});
    end
    #1;
    chk("m_rfWrtEn", rfWrtEn, ewen);
    if (ewen) begin
      chk("m_rfWrtIndex", rfWrtIndex, eidx);
      chk("m_rfDataIn", rfDataIn, edat);
    end
    chk("m_ldReady", ldReady, mq.size() < LD_DEPTH);
    chk("m_aluHold", aluHold, mq.size() == LD_DEPTH);
    chk("m_sbOverflow", sbOverflow, movf);
    chk("m_stall", stall,
        (mc[rdIndex1] != 0) || (mc[rdIndex2] != 0));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    aluWrtEn = 0; ldValid = 0; issueLd = 0;
  endtask

  initial begin
    reset_n = 0;
    aluWrtEn = 0; aluWrtIndex = 0; aluData = 0;
    ldValid = 0; ldIndex = 0; ldData = 0;
    issueLd = 0; issueLdIndex = 0;
    rdIndex1 = 0; rdIndex2 = 0;
    #1;
    chk("rst_rfWrtEn", rfWrtEn, 0);
    chk("rst_ldReady", ldReady, 1);
    chk("rst_aluHold", aluHold, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ovf", sbOverflow, 0);
    cyc(); cyc();
    reset_n = 1;
    cyc();

    // Basic load on r5
    issueLd = 1; issueLdIndex = 5; rdIndex1 = 5; rdIndex2 = 0;
    cyc();
    chk("basic_stall_on", stall, 1);
    issueLd = 0;
    cyc();
    ldValid = 1; ldIndex = 5; ldData = 32'hDEADBEEF;
    cyc();
    chk("basic_no_bypass", rfWrtEn, 0);
    ldValid = 0;
    cyc();
    chk("basic_wen", rfWrtEn, 1);
    chk("basic_idx", rfWrtIndex, 5);
    chk("basic_dat", rfDataIn, 32'hDEADBEEF);
    chk("basic_stall_hold", stall, 1);
    cyc();
    chk("basic_stall_off", stall, 0);
    rdIndex1 = 0;

    // ALU and load return at the same edge
    aluWrtEn = 1; aluWrtIndex = 1; aluData = 32'h11;
    ldValid = 1; ldIndex = 2; ldData = 32'h22;
    cyc();
    idle();
    chk("conf_alu_idx", rfWrtIndex, 1);
    chk("conf_alu_dat", rfDataIn, 32'h11);
    cyc();
    chk("conf_ld_wen", rfWrtEn, 1);
    chk("conf_ld_idx", rfWrtIndex, 2);
    chk("conf_ld_dat", rfDataIn, 32'h22);
    cyc();

    // Backpressure while ALU holds the port
    aluWrtEn = 1; aluWrtIndex = 9;
    for (int i = 0; i < 6; i++) begin
      aluData = 32'h100 + i;
      if (i == 0) begin ldValid = 1; ldIndex = 3; ldData = 32'hA; end
      if (i == 1) begin ldIndex = 4; ldData = 32'hB; end
      if (i == 2) begin
        chk("bp_ldReady", ldReady, 0);
        chk("bp_aluHold", aluHold, 1);
        ldIndex = 8; ldData = 32'hC;
      end
      cyc();
    end
    chk("bp_alu_last", rfDataIn, 32'h105);
    aluWrtEn = 0;
    cyc();
    chk("bp_w1_idx", rfWrtIndex, 3);
    chk("bp_w1_dat", rfDataIn, 32'hA);
    chk("bp_ready_back", ldReady, 1);
    cyc();
    ldValid = 0;
    chk("bp_w2_idx", rfWrtIndex, 4);
    chk("bp_w2_dat", rfDataIn, 32'hB);
    cyc();
    chk("bp_w3_idx", rfWrtIndex, 8);
    chk("bp_w3_dat", rfDataIn, 32'hC);
    cyc();
    chk("bp_idle", rfWrtEn, 0);

    // WAW kill on r7
    rdIndex1 = 7;
    issueLd = 1; issueLdIndex = 7;
    ldValid = 1; ldIndex = 7; ldData = 32'h55;
    cyc();
    idle();
    aluWrtEn = 1; aluWrtIndex = 7; aluData = 32'h77;
    cyc();
    aluWrtEn = 0;
    chk("waw_alu_dat", rfDataIn, 32'h77);
    chk("waw_stall", stall, 1);
    cyc();
    chk("waw_killed_pop", rfWrtEn, 0);
    cyc();
    chk("waw_released", stall, 0);

    // Scoreboard overflow on r3
    rdIndex1 = 3;
    issueLd = 1; issueLdIndex = 3;
    for (int i = 0; i < 4; i++) cyc();
    issueLd = 0;
    chk("ovf_set", sbOverflow, 1);
    chk("ovf_stall", stall, 1);
    for (int i = 0; i < 3; i++) begin
      ldValid = 1; ldIndex = 3; ldData = 32'h30 + i;
      cyc();
      ldValid = 0;
      cyc(); cyc();
    end
    cyc();
    chk("ovf_stall_clear", stall, 0);
    chk("ovf_sticky", sbOverflow, 1);

    // Reset while loads are buffered
    rdIndex1 = 6;
    issueLd = 1; issueLdIndex = 6;
    cyc(); cyc();
    issueLd = 0;
    aluWrtEn = 1; aluWrtIndex = 1; aluData = 32'h99;
    ldValid = 1; ldIndex = 6; ldData = 32'h61;
    cyc();
    ldData = 32'h62;
    cyc();
    chk("mid_full", aluHold, 1);
    chk("mid_stall", stall, 1);
    #1 reset_n = 0;
    #1;
    chk("mid_rst_wen", rfWrtEn, 0);
    chk("mid_rst_idx", rfWrtIndex, 0);
    chk("mid_rst_dat", rfDataIn, 0);
    chk("mid_rst_ready", ldReady, 1);
    chk("mid_rst_hold", aluHold, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_ovf", sbOverflow, 0);
    idle();
    cyc();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mid_no_stale", rfWrtEn, 0);
    end
    chk("mid_stall_after", stall, 0);

    // Randomized traffic on a few registers to force collisions
    for (int i = 0; i < 3000; i++) begin
      aluWrtEn = ($urandom % 10) < 4;
      aluWrtIndex = IW'($urandom % 4);
      aluData = $urandom;
      if (!(ldValid && !ld_acc)) begin
        ldValid = ($urandom % 10) < 5;
        ldIndex = IW'($urandom % 4);
        ldData = $urandom;
      end
      issueLd = ($urandom % 10) < 3;
      issueLdIndex = IW'($urandom % 4);
      rdIndex1 = IW'($urandom % 4);
      rdIndex2 = IW'($urandom % 4);
      if (i == 1500) begin
        reset_n = 0;
        ldValid = 0;
      end
      cyc();
      reset_n = 1;
    end
    idle();
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Sequences the register file's single write port between ALU writeback and returning loads, and keeps a per-register scoreboard of outstanding loads. The register file does not forward load results, so this block stalls decode until the load data is in the array. It sits between the writeback stage / memory return path and the register file's `wrtEn`, `wrtIndex` and `dataIn` inputs. Load returns that lose the write port wait in a small in-order buffer.

## Interface
- `INDEX_BIT_WIDTH`, 4: register index width.
- `DATA_BIT_WIDTH`, 32: data width.
- `N_REGS`, `1 << INDEX_BIT_WIDTH`: number of scoreboard entries.
- `LD_DEPTH`, 2: load buffer entries (≥1).

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `aluWrtEn`  in  1  ALU writeback request.
- `aluWrtIndex`  in  INDEX_BIT_WIDTH  ALU destination register.
- `aluData`  in  DATA_BIT_WIDTH  ALU result.
- `ldValid`  in  1  load data return valid.
- `ldIndex`  in  INDEX_BIT_WIDTH  load destination register.
- `ldData`  in  DATA_BIT_WIDTH  load data.
- `ldReady`  out  1  buffer can accept; equals not-full (combinational).
- `issueLd`  in  1  a load to `issueLdIndex` was issued this cycle.
- `issueLdIndex`  in  INDEX_BIT_WIDTH  issued load destination.
- `rdIndex1`, `rdIndex2`  in  INDEX_BIT_WIDTH  decode read indices.
- `stall`  out  1  combinational; `count[rdIndex1]!=0 | count[rdIndex2]!=0`.
- `aluHold`  out  1  combinational; buffer full (advisory to upstream).
- `rfWrtEn`, `rfWrtIndex`, `rfDataIn`  out  1/INDEX/DATA  registered; drive the register file write port.
- `sbOverflow`  out  1  sticky error flag.

## Operation
- **Scoreboard:** one 2-bit count per register.
  - `issueLd` increments the selected count.
  - A load-release event decrements it.
  - Increment and decrement of the same index in the same cycle leave the count unchanged.
  - An increment at count 3 is dropped and sets `sbOverflow`, which is cleared only by reset.
- **Load buffer:** an in-order FIFO of `{index, data, killed}`.
  - A push occurs on `ldValid & ldReady`.
  - The upstream source holds `ldValid`, `ldIndex` and `ldData` stable while `ldReady` is 0.
- **WAW kill:** the `killed` bit of a buffered entry is set on any `aluWrtEn` with `aluWrtIndex` equal to the entry index.
  - This applies to entries already in the buffer and to an entry being pushed in the same cycle; in that case ALU counts as newer.
- **Write-port arbitration, evaluated each cycle:**
  1. If `aluWrtEn`: the port takes the ALU write. A killed head entry may pop in the same cycle without using the port.
  2. Otherwise, if the buffer is non-empty: pop the head. The port takes it with `rfWrtEn = ~killed`.
  3. Otherwise: `rfWrtEn` is 0; `rfWrtIndex` and `rfDataIn` hold their previous values.
- **Load release:** every popped entry, killed or not, generates exactly one decrement of `count[index]`, applied one edge after the pop edge.
- **ALU priority:** ALU always wins, even while `aluHold` is 1. There is no starvation guard; upstream honouring `aluHold` guarantees drain.

## Timing
- **Reset values:** all counts 0, buffer empty, `rfWrtEn`/`rfWrtIndex`/`rfDataIn` 0, `sbOverflow` 0. Consequently `ldReady` = 1, `aluHold` = 0, `stall` = 0.
- **Reset mid-operation:** buffered loads and pending counts are discarded. No write is issued after `reset_n` falls.
- **ALU latency:** request sampled at edge N; `rfWrtEn` high from N until N+1; the register file captures at N+1.
- **Load latency:** pushed at edge N; earliest pop at N+1; the register file captures at N+2; the count decrements at N+2. `stall` can therefore drop in the cycle after the register file write.
- **Full buffer:** `ldReady` = 0. With a simultaneous pop, there is still no same-cycle push; `ldReady` rises the cycle after the pop.
- **Empty buffer:** no pop; `ldValid` does not bypass the buffer.
- **Issue and release:** a same-edge issue and release on different indices are both applied.

## Test plan
- **Basic load:** reset, then `issueLd` r5 at edge 1. With `rdIndex1`=5, `stall`=1 from edge 1. `ldValid` r5=0xDEADBEEF accepted at edge 3 -> `rfWrtEn`=1, index 5, data 0xDEADBEEF after edge 4; `stall`=0 after edge 5.
- **Same-cycle conflict:** `aluWrtEn` r1=0x11 and `ldValid` r2=0x22 at the same edge N -> r1 written after N; r2 written after N+1.
- **Backpressure:** `aluWrtEn` held for 6 cycles while loads r3=0xA, r4=0xB arrive -> `ldReady`=0 and `aluHold`=1 after two pushes; a third `ldValid` is held. After ALU drops, writes occur in order r3, r4, then the third load; `ldReady` returns to 1.
- **WAW kill:** load r7=0x55 buffered, then `aluWrtEn` r7=0x77 -> ALU write 0x77 issued; the r7 entry pops with `rfWrtEn`=0; count[7] returns to 0; the register file holds 0x77.
- **Scoreboard overflow:** four `issueLd` r3 without returns -> count[3]=3 and `sbOverflow`=1. Three returns clear `stall`; `sbOverflow` stays 1.
- **Reset mid-flight:** `reset_n` low while 2 loads are buffered and count[6]=2 -> all outputs return to reset values immediately. After release, no stale writes occur and `stall` is 0.
